// File: rtl/sync_prefill_fifo_mc.sv
// sync_prefill_fifo_mc
// Single-clock multi-lane FIFO with a shared pointer pair. Reads are held back
// until a programmable prefill level is reached, or until an end-of-frame drain
// opens them. Provides occupancy, almost flags, sticky error flags and a flush
// that empties the FIFO without touching the storage array.
//
// Handshake: a write is taken on a rising edge when wr_en is high, the FIFO is
// not full and the FSM is not draining. A read is taken when rd_en is high, the
// FIFO is not empty and the read gate is open. Both can be taken on the same
// edge. A write never makes a read legal on the same edge. A read never makes
// room for a write on the same edge. rd_valid pulses for one cycle after each
// taken read, and rd_data holds until the next taken read.
module sync_prefill_fifo_mc #(
  parameter int DATA_WIDTH    = 8,
  parameter int FIFO_DEPTH    = 16,
  parameter int NUM_CH        = 1,
  parameter int AFULL_MARGIN  = 2,
  parameter int AEMPTY_MARGIN = 2,
  parameter int GATE_READ     = 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             flush,
  input  logic                             drain,
  input  logic [$clog2(FIFO_DEPTH):0]      prefill_level,
  input  logic                             wr_en,
  input  logic [NUM_CH*DATA_WIDTH-1:0]     wr_data,
  output logic                             full,
  output logic                             almost_full,
  input  logic                             rd_en,
  output logic [NUM_CH*DATA_WIDTH-1:0]     rd_data,
  output logic                             rd_valid,
  output logic                             empty,
  output logic                             almost_empty,
  output logic [$clog2(FIFO_DEPTH):0]      count,
  output logic                             prefill_done,
  output logic [1:0]                       state,
  output logic                             overflow,
  output logic                             underflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int DW = NUM_CH * DATA_WIDTH;

  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] AF_TH   = CW'(FIFO_DEPTH - AFULL_MARGIN);
  localparam logic [CW-1:0] AE_TH   = CW'(AEMPTY_MARGIN);
  localparam logic          UNGATED = (GATE_READ == 0);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FILL   = 2'd1,
    ST_STREAM = 2'd2,
    ST_DRAIN  = 2'd3
  } state_t;

  state_t          st_q;
  logic [AW-1:0]   wr_ptr_q;
  logic [AW-1:0]   rd_ptr_q;
  logic [CW-1:0]   count_q;
  logic [DW-1:0]   mem [FIFO_DEPTH];

  logic [CW-1:0]   lvl;
  logic            gate_open;
  logic            wr_acc;
  logic            rd_acc;
  logic [CW-1:0]   count_next;

  // Effective prefill level: zero means one entry, oversized values saturate at depth.
  always_comb begin
    lvl = prefill_level;
    if (prefill_level == '0) begin
      lvl = CW'(1);
    end else if (prefill_level > DEPTH_C) begin
      lvl = DEPTH_C;
    end
  end

  // Accept decisions and next occupancy, all from registered state only.
  always_comb begin
    gate_open  = (st_q == ST_STREAM) || (st_q == ST_DRAIN) || UNGATED;
    wr_acc     = wr_en && !full && (st_q != ST_DRAIN);
    rd_acc     = rd_en && !empty && gate_open;
    count_next = count_q + CW'(wr_acc) - CW'(rd_acc);
  end

  assign full         = (count_q == DEPTH_C);
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= AF_TH);
  assign almost_empty = (count_q <= AE_TH);
  assign count        = count_q;
  assign state        = st_q;

  // Storage array; flush leaves contents alone, only pointers move back.
  always_ff @(posedge clk) begin
    if (!rst && !flush && wr_acc) begin
      mem[wr_ptr_q] <= wr_data;
    end
  end

  // Pointers, occupancy, FSM, read data and sticky errors.
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q         <= ST_IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      rd_data      <= '0;
      rd_valid     <= 1'b0;
      prefill_done <= 1'b0;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else if (flush) begin
      // rd_data deliberately holds its last value across a flush.
      st_q         <= ST_IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      rd_valid     <= 1'b0;
      prefill_done <= 1'b0;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      count_q  <= count_next;
      rd_valid <= rd_acc;
      if (wr_acc) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (rd_acc) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
        rd_data  <= mem[rd_ptr_q];
      end
      if (wr_en && !wr_acc) begin
        overflow <= 1'b1;
      end
      if (rd_en && !rd_acc) begin
        underflow <= 1'b1;
      end

      case (st_q)
        ST_IDLE: begin
          if (drain) begin
            st_q         <= ST_DRAIN;
            prefill_done <= 1'b1;
          end else if (wr_acc && (count_next >= lvl)) begin
            st_q         <= ST_STREAM;
            prefill_done <= 1'b1;
          end else if (wr_acc) begin
            st_q         <= ST_FILL;
          end
        end
        ST_FILL: begin
          // Drain at end of frame stops writes and lets the partial fill out.
          if (drain) begin
            st_q         <= ST_DRAIN;
            prefill_done <= 1'b1;
          end else if (count_next >= lvl) begin
            st_q         <= ST_STREAM;
            prefill_done <= 1'b1;
          end
        end
        ST_STREAM: begin
          if (drain) begin
            st_q <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (count_next == '0) begin
            st_q         <= ST_IDLE;
            prefill_done <= 1'b0;
          end
        end
        default: begin
          st_q         <= ST_IDLE;
          prefill_done <= 1'b0;
        end
      endcase
    end
  end

endmodule
